// File: rtl/ir_queue.sv
`default_nettype none
// ============================================================================
// Module      : ir_queue
// Description : LC-3b instruction queue. Buffers up to DEPTH fetched 16-bit
//               words in FIFO order behind valid/ready handshakes and presents
//               the head entry together with its decoded instruction fields.
//               A flush discards all entries on a control-flow redirect.
// Revision    : 1.0 - initial release
// ============================================================================
module ir_queue #(
    parameter int DEPTH      = 4,
    parameter bit ZERO_EMPTY = 1'b1
) (
    input  logic                       clk,
    input  logic                       reset_n,
    input  logic                       flush,
    input  logic                       in_valid,
    input  logic [15:0]                in,
    output logic                       in_ready,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic [15:0]                head,
    output logic [3:0]                 opcode,
    output logic [2:0]                 dest,
    output logic [2:0]                 src1,
    output logic [2:0]                 src2,
    output logic                       imm5_enable,
    output logic                       ashf,
    output logic                       jsr_enable,
    output logic                       dshf,
    output logic [3:0]                 imm4,
    output logic [4:0]                 imm5,
    output logic [7:0]                 trapvect8,
    output logic [5:0]                 offset6,
    output logic [8:0]                 offset9,
    output logic [10:0]                offset11
);

    localparam int c_PTR_W = $clog2(DEPTH);
    localparam int c_CNT_W = $clog2(DEPTH + 1);
    localparam logic [c_CNT_W-1:0] c_DEPTH_CNT = c_CNT_W'(DEPTH);
    localparam logic [c_PTR_W-1:0] c_PTR_ONE   = c_PTR_W'(1);
    localparam logic [c_CNT_W-1:0] c_CNT_ONE   = c_CNT_W'(1);

    logic [15:0]        r_mem [DEPTH];
    logic [c_PTR_W-1:0] r_wp;
    logic [c_PTR_W-1:0] r_rp;
    logic [c_CNT_W-1:0] r_count;

    logic               w_push;
    logic               w_pop;
    logic               w_empty;
    logic [15:0]        w_head;

    // Handshake qualification; full/empty come only from the count register,
    // so in_ready never sees out_ready and out_valid never sees in_valid.
    always_comb begin
        w_empty   = (r_count == '0);
        in_ready  = (r_count < c_DEPTH_CNT);
        out_valid = !w_empty;
        w_push    = in_valid && in_ready;
        w_pop     = out_valid && out_ready;
        count     = r_count;
    end

    // Pointer and occupancy tracking; reset beats flush, flush beats handshakes.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_wp    <= '0;
            r_rp    <= '0;
            r_count <= '0;
        end else if (flush) begin
            r_wp    <= '0;
            r_rp    <= '0;
            r_count <= '0;
        end else begin
            if (w_push) begin
                r_wp <= r_wp + c_PTR_ONE;
            end
            if (w_pop) begin
                r_rp <= r_rp + c_PTR_ONE;
            end
            if (w_push && !w_pop) begin
                r_count <= r_count + c_CNT_ONE;
            end else if (w_pop && !w_push) begin
                r_count <= r_count - c_CNT_ONE;
            end
        end
    end

    // Entry storage; contents are never cleared, only the pointers are.
    always_ff @(posedge clk) begin
        if (reset_n && !flush && w_push) begin
            r_mem[r_wp] <= in;
        end
    end

    // Head selection, optionally masked to zero while the queue is empty.
    generate
        if (ZERO_EMPTY) begin : g_zero_empty
            always_comb begin
                w_head = w_empty ? 16'h0000 : r_mem[r_rp];
            end
        end else begin : g_stale_head
            always_comb begin
                w_head = r_mem[r_rp];
            end
        end
    endgenerate

    // Field decode is a pure slice of the selected head word.
    always_comb begin
        head        = w_head;
        opcode      = w_head[15:12];
        dest        = w_head[11:9];
        src1        = w_head[8:6];
        src2        = w_head[2:0];
        imm5_enable = w_head[5];
        ashf        = w_head[5];
        jsr_enable  = w_head[11];
        dshf        = w_head[4];
        imm4        = w_head[3:0];
        imm5        = w_head[4:0];
        trapvect8   = w_head[7:0];
        offset6     = w_head[5:0];
        offset9     = w_head[8:0];
        offset11    = w_head[10:0];
    end

endmodule
`default_nettype wire

// File: tb/tb_ir_queue.sv
`default_nettype none
// ============================================================================
// Module      : tb_ir_queue
// Description : Directed self-checking bench for ir_queue (DEPTH=4,
//               ZERO_EMPTY=1) with hand-computed expected values.
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_ir_queue;

    logic        clk;
    logic        reset_n;
    logic        flush;
    logic        in_valid;
    logic [15:0] in;
    logic        in_ready;
    logic        out_valid;
    logic        out_ready;
    logic [2:0]  count;
    logic [15:0] head;
    logic [3:0]  opcode;
    logic [2:0]  dest;
    logic [2:0]  src1;
    logic [2:0]  src2;
    logic        imm5_enable;
    logic        ashf;
    logic        jsr_enable;
    logic        dshf;
    logic [3:0]  imm4;
    logic [4:0]  imm5;
    logic [7:0]  trapvect8;
    logic [5:0]  offset6;
    logic [8:0]  offset9;
    logic [10:0] offset11;

    int total = 0;
    int bad   = 0;

    ir_queue #(.DEPTH(4), .ZERO_EMPTY(1'b1)) dut (
        .clk(clk), .reset_n(reset_n), .flush(flush),
        .in_valid(in_valid), .in(in), .in_ready(in_ready),
        .out_valid(out_valid), .out_ready(out_ready), .count(count),
        .head(head), .opcode(opcode), .dest(dest), .src1(src1), .src2(src2),
        .imm5_enable(imm5_enable), .ashf(ashf), .jsr_enable(jsr_enable),
        .dshf(dshf), .imm4(imm4), .imm5(imm5), .trapvect8(trapvect8),
        .offset6(offset6), .offset9(offset9), .offset11(offset11)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one edge; inputs change and outputs are sampled 1ns after it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push_one(input logic [15:0] w);
        in_valid = 1'b1;
        in       = w;
        step();
        in_valid = 1'b0;
    endtask

    task automatic test_reset();
        reset_n = 1'b0; flush = 1'b0; in_valid = 1'b0; in = 16'h0; out_ready = 1'b0;
        step(); step();
        reset_n = 1'b1;
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
        total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
        total++; if (count !== 3'd0) begin bad++; $display("FAIL reset_count got=%0d exp=0", count); end
        total++; if (head !== 16'h0) begin bad++; $display("FAIL reset_head got=%h exp=0000", head); end
    endtask

    task automatic test_single();
        push_one(16'h1283);
        total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL single_out_valid got=%b exp=1", out_valid); end
        total++; if (count !== 3'd1) begin bad++; $display("FAIL single_count got=%0d exp=1", count); end
        total++; if (opcode !== 4'd1) begin bad++; $display("FAIL single_opcode got=%h exp=1", opcode); end
        total++; if (dest !== 3'd1) begin bad++; $display("FAIL single_dest got=%0d exp=1", dest); end
        total++; if (src1 !== 3'd2) begin bad++; $display("FAIL single_src1 got=%0d exp=2", src1); end
        total++; if (imm5_enable !== 1'b0) begin bad++; $display("FAIL single_imm5en got=%b exp=0", imm5_enable); end
        total++; if (src2 !== 3'd3) begin bad++; $display("FAIL single_src2 got=%0d exp=3", src2); end
        out_ready = 1'b1; step(); out_ready = 1'b0;
        total++; if (count !== 3'd0) begin bad++; $display("FAIL single_pop_count got=%0d exp=0", count); end
        total++; if (head !== 16'h0) begin bad++; $display("FAIL single_pop_head got=%h exp=0000", head); end
    endtask

    task automatic test_order();
        in_valid = 1'b1;
        in = 16'h1AA5; step();
        in = 16'hF025; step();
        in = 16'h4805; step();
        in_valid = 1'b0;
        total++; if (count !== 3'd3) begin bad++; $display("FAIL order_count got=%0d exp=3", count); end
        total++; if (head !== 16'h1AA5) begin bad++; $display("FAIL order_head0 got=%h exp=1aa5", head); end
        total++; if (dest !== 3'd5) begin bad++; $display("FAIL order_dest got=%0d exp=5", dest); end
        total++; if (src1 !== 3'd2) begin bad++; $display("FAIL order_src1 got=%0d exp=2", src1); end
        total++; if (imm5_enable !== 1'b1) begin bad++; $display("FAIL order_imm5en got=%b exp=1", imm5_enable); end
        total++; if (ashf !== 1'b1) begin bad++; $display("FAIL order_ashf got=%b exp=1", ashf); end
        total++; if (imm5 !== 5'd5) begin bad++; $display("FAIL order_imm5 got=%h exp=05", imm5); end
        total++; if (dshf !== 1'b0) begin bad++; $display("FAIL order_dshf got=%b exp=0", dshf); end
        out_ready = 1'b1; step();
        total++; if (head !== 16'hF025) begin bad++; $display("FAIL order_head1 got=%h exp=f025", head); end
        total++; if (opcode !== 4'hF) begin bad++; $display("FAIL order_opcode got=%h exp=f", opcode); end
        total++; if (trapvect8 !== 8'h25) begin bad++; $display("FAIL order_trapvect8 got=%h exp=25", trapvect8); end
        total++; if (offset6 !== 6'h25) begin bad++; $display("FAIL order_offset6 got=%h exp=25", offset6); end
        step();
        total++; if (head !== 16'h4805) begin bad++; $display("FAIL order_head2 got=%h exp=4805", head); end
        total++; if (jsr_enable !== 1'b1) begin bad++; $display("FAIL order_jsr got=%b exp=1", jsr_enable); end
        total++; if (offset11 !== 11'h005) begin bad++; $display("FAIL order_offset11 got=%h exp=005", offset11); end
        total++; if (offset9 !== 9'h005) begin bad++; $display("FAIL order_offset9 got=%h exp=005", offset9); end
        total++; if (imm4 !== 4'h5) begin bad++; $display("FAIL order_imm4 got=%h exp=5", imm4); end
        step(); out_ready = 1'b0;
        total++; if (count !== 3'd0) begin bad++; $display("FAIL order_empty_count got=%0d exp=0", count); end
    endtask

    task automatic test_full();
        logic [15:0] exp_heads [3];
        exp_heads[0] = 16'h1003; exp_heads[1] = 16'hABCD; exp_heads[2] = 16'h0000;
        in_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            in = 16'h1000 + 16'(i);
            step();
            if (i == 3) begin
                total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL full_in_ready got=%b exp=0", in_ready); end
            end
        end
        total++; if (count !== 3'd4) begin bad++; $display("FAIL full_count got=%0d exp=4", count); end
        total++; if (head !== 16'h1000) begin bad++; $display("FAIL full_head got=%h exp=1000", head); end
        in = 16'hABCD; out_ready = 1'b1;
        total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL full_ready_indep got=%b exp=0", in_ready); end
        step();
        total++; if (count !== 3'd3) begin bad++; $display("FAIL full_pop_only_count got=%0d exp=3", count); end
        total++; if (head !== 16'h1001) begin bad++; $display("FAIL full_pop_only_head got=%h exp=1001", head); end
        step();
        in_valid = 1'b0;
        total++; if (count !== 3'd3) begin bad++; $display("FAIL full_pushpop_count got=%0d exp=3", count); end
        total++; if (head !== 16'h1002) begin bad++; $display("FAIL full_pushpop_head got=%h exp=1002", head); end
        for (int i = 0; i < 3; i++) begin
            step();
            total++; if (head !== exp_heads[i]) begin bad++; $display("FAIL full_drain_head%0d got=%h exp=%h", i, head, exp_heads[i]); end
        end
        out_ready = 1'b0;
        total++; if (count !== 3'd0) begin bad++; $display("FAIL full_drain_count got=%0d exp=0", count); end
    endtask

    task automatic test_back_to_back();
        push_one(16'h2000);
        in_valid = 1'b1; out_ready = 1'b1;
        for (int i = 0; i < 10; i++) begin
            in = 16'h2001 + 16'(i);
            total++; if (head !== 16'h2000 + 16'(i)) begin bad++; $display("FAIL stream_head%0d got=%h exp=%h", i, head, 16'h2000 + 16'(i)); end
            total++; if (count !== 3'd1) begin bad++; $display("FAIL stream_count%0d got=%0d exp=1", i, count); end
            step();
        end
        in_valid = 1'b0;
        total++; if (head !== 16'h200A) begin bad++; $display("FAIL stream_last got=%h exp=200a", head); end
        step(); out_ready = 1'b0;
        total++; if (count !== 3'd0) begin bad++; $display("FAIL stream_empty got=%0d exp=0", count); end
    endtask

    task automatic test_flush();
        in_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            in = 16'h3000 + 16'(i);
            step();
        end
        total++; if (count !== 3'd3) begin bad++; $display("FAIL flush_pre_count got=%0d exp=3", count); end
        flush = 1'b1; in = 16'h0E01; out_ready = 1'b1;
        step();
        flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        total++; if (count !== 3'd0) begin bad++; $display("FAIL flush_count got=%0d exp=0", count); end
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL flush_out_valid got=%b exp=0", out_valid); end
        total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL flush_in_ready got=%b exp=1", in_ready); end
        total++; if (head !== 16'h0) begin bad++; $display("FAIL flush_head got=%h exp=0000", head); end
        total++; if (opcode !== 4'h0 || trapvect8 !== 8'h0 || offset11 !== 11'h0)
            begin bad++; $display("FAIL flush_fields got=%h/%h/%h exp=0/00/000", opcode, trapvect8, offset11); end
        push_one(16'h5042);
        total++; if (count !== 3'd1) begin bad++; $display("FAIL flush_next_count got=%0d exp=1", count); end
        total++; if (head !== 16'h5042) begin bad++; $display("FAIL flush_next_head got=%h exp=5042", head); end
        out_ready = 1'b1; step(); out_ready = 1'b0;
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL flush_sole got=%b exp=0", out_valid); end
    endtask

    task automatic test_reset_mid();
        push_one(16'h6001);
        push_one(16'h6002);
        total++; if (count !== 3'd2) begin bad++; $display("FAIL rst_pre_count got=%0d exp=2", count); end
        reset_n = 1'b0; in_valid = 1'b1; in = 16'h7777;
        step();
        reset_n = 1'b1; in_valid = 1'b0;
        total++; if (count !== 3'd0) begin bad++; $display("FAIL rst_count got=%0d exp=0", count); end
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL rst_out_valid got=%b exp=0", out_valid); end
        total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL rst_in_ready got=%b exp=1", in_ready); end
        total++; if (head !== 16'h0) begin bad++; $display("FAIL rst_head got=%h exp=0000", head); end
        step();
        total++; if (count !== 3'd0) begin bad++; $display("FAIL rst_nothing_enq got=%0d exp=0", count); end
    endtask

    initial begin
        test_reset();
        test_single();
        test_order();
        test_full();
        test_back_to_back();
        test_flush();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
